seven_segment_capture: RTL
==========================

# seven_segment_capture

Reader side of the multiplexed seven-segment display interface. Watches the active-low segment bus and active-low digit-enable lines of a time-multiplexed display and waits for each digit's pattern to hold steady. It decodes each stable pattern back to a 4-bit value and presents one full multi-digit frame through a valid/ready handshake. Used as an on-chip display monitor and as a self-check path for the 4x4 multiplier display output.

## Interface
- `NUM_DIGITS`, default 4: number of multiplexed digits and capture slots; range 1–8.
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a digit is accepted; range 2–255.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `seg_in`  in  7: segment bus, active-low, bit0 = a … bit6 = g (pattern for "0" = 7'b1000000).
- `an_in`  in  NUM_DIGITS: digit enables, active-low. Bit i low selects digit i.
- `start`  in  1: one-cycle pulse that begins (or restarts) a frame capture.
- `busy`  out  1: high in CAPTURE and HOLD.
- `frame_valid`  out  1: frame available.
- `frame_ready`  in  1: consumer accepts the frame.
- `frame_data`  out  4*NUM_DIGITS: digit i in bits [4i+3:4i].
- `frame_err`  out  NUM_DIGITS: bit i set if digit i held a blank or unrecognised pattern.

## Operation
- **Input stage:** `seg_in` and `an_in` are registered once (`seg_q`, `an_q`). All logic below operates on the registered copies.
- **Qualifier:** a sample is *qualifying* when `an_q` has exactly one bit low.
- **Stability counter:**
  - Cleared to 0 when the sample is not qualifying, or when `{an_q,seg_q}` differs from the previous cycle.
  - Otherwise increments, saturating at STABLE_CYCLES-1.
- **Slot write:** when the counter reaches STABLE_CYCLES-1 and the slot for the low `an_q` bit is not yet marked, the block writes the decoded value and error bit into that slot and sets its mask bit. Each slot is written at most once per frame; later patterns for a marked slot are ignored.
- **Decode:**
  - Patterns 0–9 (1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000) → 4'h0–4'h9, err=0.
  - Any other pattern, including blank 1111111 → value 4'h0, err=1.
- **FSM states: IDLE, CAPTURE, HOLD.**
  - IDLE → CAPTURE on `start`. This clears the mask, the slots and the counter.
  - CAPTURE → HOLD on the edge that sets the last mask bit.
  - `start` in CAPTURE restarts the capture and clears the mask.
  - HOLD → IDLE on `frame_valid && frame_ready`.
  - `start` in HOLD is ignored.
- **Outputs in HOLD:**
  - `frame_valid` = 1.
  - `frame_data` and `frame_err` are stable and held until the handshake completes.
- **Outputs outside HOLD:** `frame_data` and `frame_err` show the current slot contents; consumers sample them only with `frame_valid`.
- **Reset values:** every output is 0 (`busy`, `frame_valid`, `frame_data`, `frame_err`). State = IDLE, mask = 0, counter = 0.

## Timing
- **Slot write latency:** suppose `seg_in`/`an_in` are held constant at the input over edges k … k+STABLE_CYCLES. The slot is then written at edge k+STABLE_CYCLES+1 (one register stage plus STABLE_CYCLES identical registered samples) and is visible after that edge.
- `frame_valid` rises on the same edge as the final slot write. There is no extra cycle.
- **Handshake:** completes on an edge where `frame_valid` and `frame_ready` are both high. `frame_valid` is low the next cycle.
  - `frame_ready` may be held high continuously.
  - `frame_valid` never depends combinationally on `frame_ready`.
- **Boundary cases:**
  - Any change of pattern or digit one cycle short of qualification resets the counter with no write.
  - `an_in` all high (inter-digit blanking gap) or more than one bit low: no write, counter cleared.
- **Reset mid-operation:** asynchronous assertion forces IDLE and zeroes every output immediately. The frame is discarded.

## Configuration
- **`SEG_CAPTURE_HEX_EN` defined:** patterns 0001000, 0000011, 1000110, 0100001, 0000110, 0001110 decode to 4'hA–4'hF with err=0.
- **Not defined:** those six patterns decode to value 4'h0 with err=1.
- Blank is always an error in both configurations.

## Test plan
- **Basic frame:** reset, then `start`. Drive digits 3,2,1,0 with patterns for 1,2,3,4, each held 8 cycles → `frame_data`=16'h1234, `frame_err`=4'b0000, `frame_valid` rises exactly STABLE_CYCLES+1 edges after the digit-0 pattern appears.
- **Glitch rejection:** drive digit 0 = "7" for STABLE_CYCLES cycles only, then "5" for 8 cycles → slot 0 = 4'h5.
- **Invalid and blank:** digit 1 blank and digit 2 = 7'b1010101 → `frame_err`=4'b0110, corresponding nibbles = 0.
- **Hex decode:** digit 0 = 7'b0000110 → 4'hE, err=0 with `SEG_CAPTURE_HEX_EN`; 4'h0, err=1 without it.
- **Backpressure:** hold `frame_ready`=0 for 20 cycles while the inputs change → `frame_data` is stable, `frame_valid` stays 1, `start` is ignored. Raise `frame_ready` → IDLE the next cycle.
- **Reset mid-capture:** assert `rst_n`=0 after two slots are captured → all outputs are 0 immediately. After release, a new `start` yields a full fresh frame with no stale digits.

Source files
------------

// File: rtl/seven_segment_capture.sv
// Captures one frame of a multiplexed active-low seven-segment display and hands it out via valid/ready.
// Define SEG_CAPTURE_HEX_EN to decode the A-F glyphs; otherwise they are flagged as errors.
module seven_segment_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [6:0]                seg_in,
  input  logic [NUM_DIGITS-1:0]     an_in,
  input  logic                      start,
  output logic                      busy,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  output logic [4*NUM_DIGITS-1:0]   frame_data,
  output logic [NUM_DIGITS-1:0]     frame_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  localparam int         IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [1:0]              state;
  logic [6:0]              seg_q, seg_prev;
  logic [NUM_DIGITS-1:0]   an_q, an_prev;
  logic [7:0]              cnt;
  logic [NUM_DIGITS-1:0]   mask;
  logic [4*NUM_DIGITS-1:0] data_q;
  logic [NUM_DIGITS-1:0]   err_q;

  logic [3:0]              low_cnt;
  logic [IDX_W-1:0]        idx;
  logic                    qualifying;
  logic                    same;
  logic [3:0]              dec_val;
  logic                    dec_err;
  logic [NUM_DIGITS-1:0]   slot_bit;
  logic                    write_en;
  logic                    last_slot;

  // Count the low enables and remember which one is selected.
  always_comb begin
    low_cnt = '0;
    idx     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) begin
        low_cnt = low_cnt + 4'd1;
        idx     = IDX_W'(i);
      end
    end
  end

  assign qualifying = (low_cnt == 4'd1);
  assign same       = (an_q == an_prev) && (seg_q == seg_prev);
  assign slot_bit   = NUM_DIGITS'(1) << idx;
  assign write_en   = (state == CAPTURE) && !start && qualifying && same &&
                      (cnt == CNT_MAX) && !mask[idx];
  assign last_slot  = write_en && ((mask | slot_bit) == '1);

  always_comb begin
    dec_val = 4'h0;
    dec_err = 1'b0;
    case (seg_q)
      7'b1000000: dec_val = 4'h0;
      7'b1111001: dec_val = 4'h1;
      7'b0100100: dec_val = 4'h2;
      7'b0110000: dec_val = 4'h3;
      7'b0011001: dec_val = 4'h4;
      7'b0010010: dec_val = 4'h5;
      7'b0000010: dec_val = 4'h6;
      7'b1111000: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0010000: dec_val = 4'h9;
`ifdef SEG_CAPTURE_HEX_EN
      7'b0001000: dec_val = 4'hA;
      7'b0000011: dec_val = 4'hB;
      7'b1000110: dec_val = 4'hC;
      7'b0100001: dec_val = 4'hD;
      7'b0000110: dec_val = 4'hE;
      7'b0001110: dec_val = 4'hF;
`endif
      default:    dec_err = 1'b1;
    endcase
  end

  // The counter compares against the previous registered sample, so a write lands one edge after saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= '0;
      an_q     <= '1;
      seg_prev <= '0;
      an_prev  <= '1;
      cnt      <= '0;
    end else begin
      seg_q    <= seg_in;
      an_q     <= an_in;
      seg_prev <= seg_q;
      an_prev  <= an_q;
      if (start && (state != HOLD))
        cnt <= '0;
      else if (!qualifying || !same)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mask   <= '0;
      data_q <= '0;
      err_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= CAPTURE;
            mask   <= '0;
            data_q <= '0;
            err_q  <= '0;
          end
        end
        CAPTURE: begin
          if (start) begin
            mask   <= '0;
            data_q <= '0;
            err_q  <= '0;
          end else if (write_en) begin
            mask                <= mask | slot_bit;
            data_q[4*idx +: 4]  <= dec_val;
            err_q[idx]          <= dec_err;
            if (last_slot)
              state <= HOLD;
          end
        end
        HOLD: begin
          if (frame_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign frame_valid = (state == HOLD);
  assign frame_data  = data_q;
  assign frame_err   = err_q;

endmodule
